// File: rtl/hazard_pkg.sv
//------------------------------------------------------------------------------
// Module   : hazard_pkg
// Purpose  : State encodings and pipeline control vectors for hazard_controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package hazard_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LU_STALL = 2'd1,
      FLUSH    = 2'd2,
      MEM_WAIT = 2'd3
   } state_t;

   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic ifid_flush;
      logic idex_write;
      logic idex_bubble;
      logic exmem_write;
      logic memwb_write;
   } ctrl_t;

   // Normal flow: every stage advances and nothing is turned into a NOP.
   localparam ctrl_t CTRL_RUN    = 7'b1101011;
   localparam ctrl_t CTRL_FREEZE = 7'b0000000;
   localparam ctrl_t CTRL_SQUASH = 7'b1111111;
   localparam ctrl_t CTRL_LU     = 7'b0001111;

endpackage : hazard_pkg

`default_nettype wire

// File: rtl/hazard_stat_counter.sv
//------------------------------------------------------------------------------
// Module   : hazard_stat_counter
// Purpose  : Saturating event counter with synchronous clear.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hazard_stat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule : hazard_stat_counter

`default_nettype wire

// File: rtl/hazard_controller.sv
//------------------------------------------------------------------------------
// Module   : hazard_controller
// Purpose  : Load-use stall, redirect squash and memory-wait freeze sequencing
//            for the 5-stage pipeline. Optional stats via HAZARD_STATS_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hazard_controller
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_useRs,
   input  logic             id_useRt,
   input  logic [4:0]       ex_regAw,
   input  logic             ex_memRead,
   input  logic             ex_redirect,
   input  logic             mem_busy,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_write,
   output logic             idex_bubble,
   output logic             exmem_write,
   output logic             memwb_write,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] lu_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] wait_cnt
);

   localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);

   state_t           state;
   state_t           next_state;
   ctrl_t            ctrl;
   logic             pending_redirect;
   logic [TMR_W-1:0] wait_timer;
   logic             load_use;
   logic             redirect;
   logic             lu_hit;

   assign load_use = ex_memRead && (ex_regAw != 5'd0) &&
                     ((id_useRs && (ex_regAw == id_rs)) ||
                      (id_useRt && (ex_regAw == id_rt)));
   assign redirect = ex_redirect || pending_redirect;
   // The stalled ID instruction is re-examined in LU_STALL; suppressing detection
   // there limits each load to a single bubble.
   assign lu_hit   = load_use && (state != LU_STALL);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = RUN;
      if (mem_busy) begin
         next_state = MEM_WAIT;
      end else if (redirect) begin
         next_state = FLUSH;
      end else if (lu_hit) begin
         next_state = LU_STALL;
      end
   end

   always_comb begin
      ctrl = CTRL_RUN;
      if (reset) begin
         ctrl = CTRL_RUN;
      end else if (mem_busy) begin
         ctrl = CTRL_FREEZE;
      end else if (redirect) begin
         ctrl = CTRL_SQUASH;
      end else if (lu_hit) begin
         ctrl = CTRL_LU;
      end
   end

   assign pc_write    = ctrl.pc_write;
   assign ifid_write  = ctrl.ifid_write;
   assign ifid_flush  = ctrl.ifid_flush;
   assign idex_write  = ctrl.idex_write;
   assign idex_bubble = ctrl.idex_bubble;
   assign exmem_write = ctrl.exmem_write;
   assign memwb_write = ctrl.memwb_write;

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_redirect <= 1'b0;
         wait_timer       <= '0;
         mem_timeout      <= 1'b0;
      end else if (mem_busy) begin
         pending_redirect <= pending_redirect || ex_redirect;
         if (wait_timer != TMR_W'(MEM_TIMEOUT)) begin
            wait_timer <= wait_timer + 1'b1;
         end
         if (wait_timer == TMR_W'(MEM_TIMEOUT - 1)) begin
            mem_timeout <= 1'b1;
         end
      end else begin
         pending_redirect <= 1'b0;
         wait_timer       <= '0;
      end
   end

`ifdef HAZARD_STATS_EN
   hazard_stat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (next_state == LU_STALL),
      .count (lu_cnt)
   );

   hazard_stat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (next_state == FLUSH),
      .count (flush_cnt)
   );

   hazard_stat_counter #(.CNT_W(CNT_W)) u_wait_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (mem_busy),
      .count (wait_cnt)
   );
`else
   assign lu_cnt    = '0;
   assign flush_cnt = '0;
   assign wait_cnt  = '0;
`endif

endmodule : hazard_controller

`default_nettype wire

// File: tb/tb_hazard_controller.sv
//------------------------------------------------------------------------------
// Module   : tb_hazard_controller
// Purpose  : Scoreboard bench for hazard_controller (MEM_TIMEOUT=4).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hazard_controller;

   localparam int CNT_W = 16;
   localparam logic [6:0] NORM = 7'b1101011;
   localparam logic [6:0] FRZ  = 7'b0000000;
   localparam logic [6:0] SQ   = 7'b1111111;
   localparam logic [6:0] LUS  = 7'b0001111;

   typedef struct {
      logic       rst, busy, redir, mr;
      logic [4:0] aw, rs, rt;
      logic       urs, urt;
      logic [6:0] exp;
   } stim_t;

   logic             clk = 1'b0;
   logic             reset, ex_memRead, ex_redirect, mem_busy, id_useRs, id_useRt;
   logic [4:0]       id_rs, id_rt, ex_regAw;
   logic             pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
   logic             exmem_write, memwb_write, mem_timeout;
   logic [CNT_W-1:0] lu_cnt, flush_cnt, wait_cnt;
   logic [6:0]       exp_q[$];
   logic [6:0]       got, want;
   int               total = 0;
   int               bad   = 0;

   hazard_controller #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
      .id_useRs(id_useRs), .id_useRt(id_useRt), .ex_regAw(ex_regAw),
      .ex_memRead(ex_memRead), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_write(idex_write), .idex_bubble(idex_bubble), .exmem_write(exmem_write),
      .memwb_write(memwb_write), .mem_timeout(mem_timeout),
      .lu_cnt(lu_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
   );

   always #5 clk = ~clk;

   wire [6:0] ctrl_vec = {pc_write, ifid_write, ifid_flush, idex_write,
                          idex_bubble, exmem_write, memwb_write};

   function automatic stim_t row(input logic rst, busy, redir, mr,
                                 input logic [4:0] aw, rs, rt,
                                 input logic urs, urt, input logic [6:0] exp);
      stim_t s;
      s.rst = rst; s.busy = busy; s.redir = redir; s.mr = mr;
      s.aw = aw; s.rs = rs; s.rt = rt; s.urs = urs; s.urt = urt; s.exp = exp;
      return s;
   endfunction

   // Counter expectations collapse to zero when statistics are not built.
   function automatic logic [CNT_W-1:0] ce(input int v);
`ifdef HAZARD_STATS_EN
      return CNT_W'(v);
`else
      return CNT_W'(v - v);
`endif
   endfunction

   task automatic apply(input stim_t s);
      reset = s.rst; mem_busy = s.busy; ex_redirect = s.redir; ex_memRead = s.mr;
      ex_regAw = s.aw; id_rs = s.rs; id_rt = s.rt; id_useRs = s.urs; id_useRt = s.urt;
   endtask

   task automatic test_reset();
      stim_t t[$];
      t.push_back(row(1, 1, 1, 1, 5'd2, 5'd2, 5'd0, 1, 0, NORM));
      t.push_back(row(1, 0, 0, 1, 5'd2, 5'd2, 5'd0, 1, 0, NORM));
      t.push_back(row(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, NORM));
      foreach (t[i]) begin
         @(negedge clk); apply(t[i]); exp_q.push_back(t[i].exp);
         #2; got = ctrl_vec; want = exp_q.pop_front(); total++;
         if (got !== want) begin
            bad++; $display("FAIL reset row %0d: ctrl=%b expected %b", i, got, want);
         end
      end
      @(negedge clk);
      total++;
      if ({lu_cnt, flush_cnt, wait_cnt} !== {3*CNT_W{1'b0}} || mem_timeout !== 1'b0) begin
         bad++; $display("FAIL reset regs: lu=%0d flush=%0d wait=%0d to=%b expected all 0",
                         lu_cnt, flush_cnt, wait_cnt, mem_timeout);
      end
   endtask

   task automatic test_load_use();
      stim_t t[$];
      t.push_back(row(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, NORM));
      t.push_back(row(0, 0, 0, 1, 5'd2, 5'd2, 5'd9, 1, 1, LUS));
      t.push_back(row(0, 0, 0, 1, 5'd2, 5'd2, 5'd9, 1, 1, NORM));
      t.push_back(row(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, NORM));
      t.push_back(row(0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0, 1, LUS));
      t.push_back(row(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, NORM));
      foreach (t[i]) begin
         @(negedge clk); apply(t[i]); exp_q.push_back(t[i].exp);
         #2; got = ctrl_vec; want = exp_q.pop_front(); total++;
         if (got !== want) begin
            bad++; $display("FAIL load_use row %0d: ctrl=%b expected %b", i, got, want);
         end
      end
      @(negedge clk);
      total++;
      if (lu_cnt !== ce(2)) begin
         bad++; $display("FAIL load_use lu_cnt: got %0d expected %0d", lu_cnt, ce(2));
      end
   endtask

   task automatic test_no_stall();
      stim_t t[$];
      t.push_back(row(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, NORM));
      t.push_back(row(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1, NORM));
      t.push_back(row(0, 0, 0, 1, 5'd3, 5'd4, 5'd3, 1, 0, NORM));
      t.push_back(row(0, 0, 0, 0, 5'd6, 5'd6, 5'd6, 1, 1, NORM));
      t.push_back(row(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, NORM));
      foreach (t[i]) begin
         @(negedge clk); apply(t[i]); exp_q.push_back(t[i].exp);
         #2; got = ctrl_vec; want = exp_q.pop_front(); total++;
         if (got !== want) begin
            bad++; $display("FAIL no_stall row %0d: ctrl=%b expected %b", i, got, want);
         end
      end
      @(negedge clk);
      total++;
      if (lu_cnt !== ce(0)) begin
         bad++; $display("FAIL no_stall lu_cnt: got %0d expected %0d", lu_cnt, ce(0));
      end
   endtask

   task automatic test_redirect();
      stim_t t[$];
      t.push_back(row(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, NORM));
      t.push_back(row(0, 0, 1, 1, 5'd2, 5'd2, 5'd0, 1, 0, SQ));
      t.push_back(row(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, NORM));
      foreach (t[i]) begin
         @(negedge clk); apply(t[i]); exp_q.push_back(t[i].exp);
         #2; got = ctrl_vec; want = exp_q.pop_front(); total++;
         if (got !== want) begin
            bad++; $display("FAIL redirect row %0d: ctrl=%b expected %b", i, got, want);
         end
      end
      @(negedge clk);
      total++;
      if (flush_cnt !== ce(1) || lu_cnt !== ce(0)) begin
         bad++; $display("FAIL redirect counts: flush=%0d lu=%0d expected flush=%0d lu=%0d",
                         flush_cnt, lu_cnt, ce(1), ce(0));
      end
   endtask

   task automatic test_mem_wait();
      stim_t t[$];
      t.push_back(row(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, NORM));
      t.push_back(row(0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, FRZ));
      t.push_back(row(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, FRZ));
      t.push_back(row(0, 1, 0, 1, 5'd7, 5'd7, 5'd0, 1, 0, FRZ));
      t.push_back(row(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, SQ));
      t.push_back(row(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, NORM));
      foreach (t[i]) begin
         @(negedge clk); apply(t[i]); exp_q.push_back(t[i].exp);
         #2; got = ctrl_vec; want = exp_q.pop_front(); total++;
         if (got !== want) begin
            bad++; $display("FAIL mem_wait row %0d: ctrl=%b expected %b", i, got, want);
         end
      end
      @(negedge clk);
      total++;
      if (wait_cnt !== ce(3) || flush_cnt !== ce(1) || lu_cnt !== ce(0) || mem_timeout !== 1'b0) begin
         bad++; $display("FAIL mem_wait regs: wait=%0d flush=%0d lu=%0d to=%b expected %0d %0d %0d 0",
                         wait_cnt, flush_cnt, lu_cnt, mem_timeout, ce(3), ce(1), ce(0));
      end
   endtask

   task automatic test_timeout();
      logic exp_to;
      stim_t busy_r, idle_r, rst_r;
      busy_r = row(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, FRZ);
      idle_r = row(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, NORM);
      rst_r  = row(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, NORM);
      @(negedge clk); apply(rst_r);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         apply((k <= 6) ? busy_r : idle_r);
         exp_q.push_back((k <= 6) ? FRZ : NORM);
         // Flag is set by the edge ending the 4th busy cycle.
         exp_to = (k >= 5);
         #2; got = ctrl_vec; want = exp_q.pop_front(); total += 2;
         if (got !== want) begin
            bad++; $display("FAIL timeout ctrl cycle %0d: ctrl=%b expected %b", k, got, want);
         end
         if (mem_timeout !== exp_to) begin
            bad++; $display("FAIL timeout flag cycle %0d: got %b expected %b", k, mem_timeout, exp_to);
         end
      end
      total++;
      if (wait_cnt !== ce(6)) begin
         bad++; $display("FAIL timeout wait_cnt: got %0d expected %0d", wait_cnt, ce(6));
      end
      @(negedge clk); apply(rst_r);
      @(negedge clk); apply(idle_r);
      #2; total++;
      if (mem_timeout !== 1'b0 || wait_cnt !== ce(0)) begin
         bad++; $display("FAIL timeout after reset: to=%b wait=%0d expected 0 0", mem_timeout, wait_cnt);
      end
   endtask

   task automatic test_reset_mid();
      stim_t t[$];
      t.push_back(row(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, NORM));
      t.push_back(row(0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 1, 0, LUS));
      t.push_back(row(1, 0, 0, 1, 5'd8, 5'd8, 5'd0, 1, 0, NORM));
      t.push_back(row(0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 1, 0, LUS));
      t.push_back(row(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, NORM));
      t.push_back(row(0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, FRZ));
      t.push_back(row(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, FRZ));
      t.push_back(row(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, NORM));
      t.push_back(row(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, NORM));
      foreach (t[i]) begin
         @(negedge clk); apply(t[i]); exp_q.push_back(t[i].exp);
         #2; got = ctrl_vec; want = exp_q.pop_front(); total++;
         if (got !== want) begin
            bad++; $display("FAIL reset_mid row %0d: ctrl=%b expected %b", i, got, want);
         end
      end
      @(negedge clk);
      total++;
      if ({lu_cnt, flush_cnt, wait_cnt} !== {3*CNT_W{1'b0}} || mem_timeout !== 1'b0) begin
         bad++; $display("FAIL reset_mid regs: lu=%0d flush=%0d wait=%0d to=%b expected all 0",
                         lu_cnt, flush_cnt, wait_cnt, mem_timeout);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      apply(row(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, NORM));
      test_reset();
      test_load_use();
      test_no_stall();
      test_redirect();
      test_mem_wait();
      test_timeout();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_hazard_controller

`default_nettype wire
